// File: rtl/cpu_fetch_pkg.sv
// cpu_fetch_pkg: shared states, redirect selectors and PC step for the fetch front end
package cpu_fetch_pkg;
  typedef enum logic {RUN, DRAIN} fetch_state_e;
  typedef enum logic [1:0] {RD_NONE, RD_BR, RD_JMP, RD_JR} redirect_sel_e;
  localparam int unsigned PC_STEP = 4;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request/response bus between fetch (master) and imem (slave)
interface fetch_unit_if #(
  parameter int XLEN = 32
);
  logic req_valid;
  logic req_ready;
  logic rsp_valid;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] rsp_data;
  modport master(output req_valid, req_addr, input req_ready, rsp_valid, rsp_data);
  modport slave(input req_valid, req_addr, output req_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with clear, full/empty flags and entry count
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign empty = cnt_q == '0;
  assign full  = cnt_q == CW'(DEPTH);
  assign count = cnt_q;
  assign dout  = empty ? '0 : mem_q[rd_q];
  always_comb begin
    do_push = push && !clear;
    do_pop  = pop && !empty && !clear;
    rd_d    = clear ? '0 : do_pop ? (rd_q == AW'(DEPTH - 1) ? '0 : rd_q + AW'(1)) : rd_q;
    wr_d    = clear ? '0 : do_push ? (wr_q == AW'(DEPTH - 1) ? '0 : wr_q + AW'(1)) : wr_q;
    cnt_d   = clear ? '0 : cnt_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: prioritised PC redirect, credit-limited imem requests and decode fetch queue
module fetch_unit
  import cpu_fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       halt,
  input  logic                       br_taken,
  input  logic [XLEN-1:0]            br_target,
  input  logic                       jmp,
  input  logic [XLEN-1:0]            jmp_target,
  input  logic                       jr,
  input  logic [XLEN-1:0]            jr_target,
  fetch_unit_if.master               imem,
  output logic                       id_valid,
  output logic [XLEN-1:0]            id_pc,
  output logic [XLEN-1:0]            id_instr,
  input  logic                       id_ready,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);
  localparam int CW = $clog2(DEPTH + 1);
  redirect_sel_e sel;
  fetch_state_e state_q, state_d;
  logic redirect, fire, rsp_keep;
  logic tag_full, tag_empty, q_full, q_empty;
  logic [XLEN-1:0] target, pc_q, pc_d, tag;
  logic [CW-1:0] out_q, out_d, drop_q, drop_d, tag_count;
  logic [2*XLEN-1:0] head;
  always_comb begin
    sel            = br_taken ? RD_BR : jmp ? RD_JMP : jr ? RD_JR : RD_NONE;
    redirect       = sel != RD_NONE;
    target         = sel == RD_BR ? br_target : sel == RD_JMP ? jmp_target : jr_target;
    target[1:0]    = 2'b00;
    imem.req_valid = !rst && !halt && !redirect
                     && ((CW+1)'(occupancy) + (CW+1)'(out_q) < (CW+1)'(DEPTH));
    imem.req_addr  = pc_q;
    fire           = imem.req_valid && imem.req_ready;
    rsp_keep       = imem.rsp_valid && state_q == RUN && !redirect;
    pc_d           = redirect ? target : fire ? pc_q + XLEN'(PC_STEP) : pc_q;
    out_d          = out_q + CW'(fire) - CW'(imem.rsp_valid);
    drop_d         = redirect ? out_q - CW'(imem.rsp_valid)
                   : imem.rsp_valid && state_q == DRAIN ? drop_q - CW'(1) : drop_q;
    state_d        = drop_d != '0 ? DRAIN : RUN;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      out_q   <= '0;
      drop_q  <= '0;
      state_q <= RUN;
    end else begin
      pc_q    <= pc_d;
      out_q   <= out_d;
      drop_q  <= drop_d;
      state_q <= state_d;
    end
  end
  // Tags are only popped for responses that are kept; dropped responses had their tags cleared.
  fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag (
    .clk(clk), .rst(rst), .push(fire), .pop(rsp_keep), .clear(redirect),
    .din(pc_q), .dout(tag), .full(tag_full), .empty(tag_empty), .count(tag_count)
  );
  fetch_fifo #(.WIDTH(2*XLEN), .DEPTH(DEPTH)) u_queue (
    .clk(clk), .rst(rst), .push(rsp_keep), .pop(id_valid && id_ready), .clear(redirect),
    .din({tag, imem.rsp_data}), .dout(head), .full(q_full), .empty(q_empty), .count(occupancy)
  );
  assign id_valid          = !q_empty;
  assign {id_pc, id_instr} = head;
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(rsp_keep && q_full));
  a_rsp_owed:    assert property (@(posedge clk) disable iff (rst) !(imem.rsp_valid && out_q == '0));
  a_tag_avail:   assert property (@(posedge clk) disable iff (rst) !(rsp_keep && tag_empty));
  a_tag_room:    assert property (@(posedge clk) disable iff (rst) !(fire && tag_full));
  a_tag_credit:  assert property (@(posedge clk) disable iff (rst) state_q != RUN || tag_count == out_q);
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit against an in-order variable-latency imem model
module tb_fetch_unit;
  localparam logic [31:0] KEY = 32'hA5A5_5A5A;
  logic clk = 0, rst = 1, halt = 0, br_taken = 0, jmp = 0, jr = 0, id_ready = 1;
  logic [31:0] br_target = 0, jmp_target = 0, jr_target = 0;
  logic id_valid;
  logic [31:0] id_pc, id_instr;
  logic [2:0] occupancy;
  int tests = 0, fails = 0, lat = 1, cyc = 0;
  logic [31:0] exp_pc, rsp_addr = 0, hs_addr;
  logic hs;
  typedef struct {logic [31:0] addr; int due;} req_t;
  req_t pend[$];
  fetch_unit_if #(.XLEN(32)) imem ();
  assign imem.req_ready = 1'b1;
  fetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .halt(halt),
    .br_taken(br_taken), .br_target(br_target),
    .jmp(jmp), .jmp_target(jmp_target),
    .jr(jr), .jr_target(jr_target),
    .imem(imem),
    .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr),
    .id_ready(id_ready), .occupancy(occupancy)
  );
  always #5 clk = ~clk;
  initial begin
    imem.rsp_valid = 0;
    imem.rsp_data = 0;
    forever begin
      @(posedge clk);
      hs = imem.req_valid && imem.req_ready;
      hs_addr = imem.req_addr;
      cyc++;
      #1;
      if (rst) pend.delete();
      else begin
        if (imem.rsp_valid) void'(pend.pop_front());
        if (hs) pend.push_back('{hs_addr, cyc + lat - 1});
      end
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        imem.rsp_valid = 1;
        rsp_addr = pend[0].addr;
        imem.rsp_data = pend[0].addr ^ KEY;
      end else imem.rsp_valid = 0;
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests++; if (id_valid !== 1'b0) begin fails++; $display("FAIL reset_id_valid: got %b want 0", id_valid); end
    tests++; if (imem.req_valid !== 1'b0) begin fails++; $display("FAIL reset_req_valid: got %b want 0", imem.req_valid); end
    tests++; if (occupancy !== 3'd0) begin fails++; $display("FAIL reset_occupancy: got %0d want 0", occupancy); end
    tests++; if (id_pc !== 32'h0 || id_instr !== 32'h0) begin fails++; $display("FAIL reset_id_data: got pc %h instr %h want 0", id_pc, id_instr); end
  endtask
  task automatic test_stream();
    rst = 0;
    #1;
    tests++; if (imem.req_valid !== 1'b1 || imem.req_addr !== 32'h0) begin fails++; $display("FAIL first_req: got v=%b addr %h want v=1 addr 0", imem.req_valid, imem.req_addr); end
    @(negedge clk);
    tests++; if (imem.req_addr !== 32'h4) begin fails++; $display("FAIL second_req: got %h want 4", imem.req_addr); end
    exp_pc = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      tests++; if (id_valid !== 1'b1 || id_pc !== exp_pc || id_instr !== (exp_pc ^ KEY)) begin fails++; $display("FAIL stream: got v=%b pc %h instr %h want pc %h instr %h", id_valid, id_pc, id_instr, exp_pc, exp_pc ^ KEY); end
      exp_pc += 4;
    end
  endtask
  task automatic test_backpressure();
    int got;
    @(negedge clk);
    id_ready = 0;
    repeat (10) @(negedge clk);
    tests++; if (occupancy !== 3'd4) begin fails++; $display("FAIL bp_occupancy: got %0d want 4", occupancy); end
    tests++; if (imem.req_valid !== 1'b0) begin fails++; $display("FAIL bp_req_valid: got %b want 0", imem.req_valid); end
    tests++; if (id_valid !== 1'b1 || id_pc !== exp_pc) begin fails++; $display("FAIL bp_head: got v=%b pc %h want pc %h", id_valid, id_pc, exp_pc); end
    id_ready = 1;
    exp_pc += 4;
    got = 0;
    for (int i = 0; i < 30 && got < 10; i++) begin
      @(negedge clk);
      if (id_valid) begin
        tests++; if (id_pc !== exp_pc || id_instr !== (exp_pc ^ KEY)) begin fails++; $display("FAIL bp_resume: got pc %h instr %h want pc %h", id_pc, id_instr, exp_pc); end
        exp_pc += 4;
        got++;
      end
    end
    tests++; if (got !== 10) begin fails++; $display("FAIL bp_resume_count: got %0d want 10", got); end
  endtask
  task automatic test_redirect_drain();
    int stale, got;
    @(negedge clk);
    halt = 1;
    repeat (8) @(negedge clk);
    tests++; if (occupancy !== 3'd0 || id_valid !== 1'b0 || imem.req_valid !== 1'b0) begin fails++; $display("FAIL halt_drained: got occ %0d id_v %b req_v %b want 0 0 0", occupancy, id_valid, imem.req_valid); end
    lat = 3;
    halt = 0;
    repeat (3) @(negedge clk);
    br_taken = 1;
    br_target = 32'h100;
    #1;
    tests++; if (imem.req_valid !== 1'b0) begin fails++; $display("FAIL redirect_blocks_req: got %b want 0", imem.req_valid); end
    stale = (imem.rsp_valid && rsp_addr !== 32'h100) ? 1 : 0;
    @(negedge clk);
    br_taken = 0;
    #1;
    tests++; if (id_valid !== 1'b0) begin fails++; $display("FAIL redirect_id_valid: got %b want 0", id_valid); end
    tests++; if (imem.req_valid !== 1'b1 || imem.req_addr !== 32'h100) begin fails++; $display("FAIL redirect_addr: got v=%b addr %h want v=1 addr 100", imem.req_valid, imem.req_addr); end
    if (imem.rsp_valid && rsp_addr !== 32'h100) stale++;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (id_valid) break;
      if (imem.rsp_valid && rsp_addr !== 32'h100) stale++;
    end
    tests++; if (stale !== 3) begin fails++; $display("FAIL drain_dropped: got %0d stale beats want 3", stale); end
    tests++; if (id_valid !== 1'b1 || id_pc !== 32'h100 || id_instr !== (32'h100 ^ KEY)) begin fails++; $display("FAIL drain_first: got v=%b pc %h instr %h want pc 100", id_valid, id_pc, id_instr); end
    exp_pc = 32'h104;
    got = 0;
    for (int i = 0; i < 30 && got < 3; i++) begin
      @(negedge clk);
      if (id_valid) begin
        tests++; if (id_pc !== exp_pc) begin fails++; $display("FAIL drain_follow: got pc %h want %h", id_pc, exp_pc); end
        exp_pc += 4;
        got++;
      end
    end
    tests++; if (got !== 3) begin fails++; $display("FAIL drain_follow_count: got %0d want 3", got); end
  endtask
  task automatic test_priority();
    lat = 1;
    @(negedge clk);
    br_taken = 1; br_target = 32'h200; jr = 1; jr_target = 32'h300;
    @(negedge clk);
    br_taken = 0; jr = 0;
    #1;
    tests++; if (imem.req_addr !== 32'h200) begin fails++; $display("FAIL prio_br_over_jr: got %h want 200", imem.req_addr); end
    for (int i = 0; i < 20; i++) begin
      if (id_valid) break;
      @(negedge clk);
    end
    tests++; if (id_valid !== 1'b1 || id_pc !== 32'h200) begin fails++; $display("FAIL prio_br_head: got v=%b pc %h want 200", id_valid, id_pc); end
    repeat (4) @(negedge clk);
    jmp = 1; jmp_target = 32'h206; jr = 1; jr_target = 32'h300;
    @(negedge clk);
    jmp = 0; jr = 0;
    #1;
    tests++; if (imem.req_addr !== 32'h204) begin fails++; $display("FAIL prio_jmp_align: got %h want 204", imem.req_addr); end
    @(negedge clk);
    tests++; if (id_valid !== 1'b0) begin fails++; $display("FAIL jmp_n2_empty: got %b want 0", id_valid); end
    @(negedge clk);
    tests++; if (id_valid !== 1'b1 || id_pc !== 32'h204) begin fails++; $display("FAIL jmp_n3_head: got v=%b pc %h want 204", id_valid, id_pc); end
    repeat (3) @(negedge clk);
    jr = 1; jr_target = 32'h30B;
    @(negedge clk);
    jr = 0;
    #1;
    tests++; if (imem.req_addr !== 32'h308) begin fails++; $display("FAIL jr_align: got %h want 308", imem.req_addr); end
  endtask
  task automatic test_wrap();
    repeat (4) @(negedge clk);
    br_taken = 1; br_target = 32'hFFFF_FFFC;
    @(negedge clk);
    br_taken = 0;
    #1;
    tests++; if (imem.req_addr !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_top: got %h want fffffffc", imem.req_addr); end
    @(negedge clk);
    tests++; if (imem.req_addr !== 32'h0) begin fails++; $display("FAIL wrap_next: got %h want 0", imem.req_addr); end
    @(negedge clk);
    tests++; if (id_valid !== 1'b1 || id_pc !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_head_top: got v=%b pc %h want fffffffc", id_valid, id_pc); end
    @(negedge clk);
    tests++; if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_instr !== KEY) begin fails++; $display("FAIL wrap_head_zero: got v=%b pc %h instr %h want pc 0 instr %h", id_valid, id_pc, id_instr, KEY); end
  endtask
  task automatic test_reset_mid();
    int got;
    id_ready = 0;
    repeat (8) @(negedge clk);
    tests++; if (occupancy !== 3'd4) begin fails++; $display("FAIL mid_full: got %0d want 4", occupancy); end
    #2 rst = 1;
    #1;
    tests++; if (id_valid !== 1'b0 || imem.req_valid !== 1'b0 || occupancy !== 3'd0) begin fails++; $display("FAIL mid_async_reset: got id_v %b req_v %b occ %0d want 0 0 0", id_valid, imem.req_valid, occupancy); end
    id_ready = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    #1;
    tests++; if (imem.req_valid !== 1'b1 || imem.req_addr !== 32'h0) begin fails++; $display("FAIL mid_restart: got v=%b addr %h want v=1 addr 0", imem.req_valid, imem.req_addr); end
    exp_pc = 0;
    got = 0;
    for (int i = 0; i < 20 && got < 4; i++) begin
      @(negedge clk);
      if (id_valid) begin
        tests++; if (id_pc !== exp_pc) begin fails++; $display("FAIL mid_stream: got pc %h want %h", id_pc, exp_pc); end
        exp_pc += 4;
        got++;
      end
    end
    tests++; if (got !== 4) begin fails++; $display("FAIL mid_stream_count: got %0d want 4", got); end
  endtask
  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_drain();
    test_priority();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
